img_sram_arbiter: RTL

Single-port arbiter that shares one `img_sram_4_64` instance between up to `NREQ` requesters (IO RX, IO TX, row-convolution engine, future DMA). It replaces hard opcode-based control multiplexing with request/grant arbitration:
- optional burst locking;
- a bounded hold time per grant;
- read-data valid routing back to the requester that issued the read.

It sits between the controllers and each SRAM's `ctrl`/`dout` ports.

---
 rtl/img_sram_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/img_sram_arbiter.sv
// Request/grant arbiter sharing one img_sram_4_64 port between NREQ requesters.
// Define IMG_SRAM_ARB_RR_EN for round-robin selection; otherwise index 0 has the highest priority.
module img_sram_arbiter #(
  parameter int unsigned NREQ      = 3,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned ROW_W     = 3,
  parameter int unsigned COL_W     = 6,
  localparam int unsigned CTRL_W   = 8 + ROW_W + COL_W + 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NREQ-1:0]              i_req,
  input  logic [NREQ-1:0]              i_lock,
  input  logic [NREQ-1:0][CTRL_W-1:0]  i_ctrl_in,
  output logic [NREQ-1:0]              o_gnt,
  output logic [NREQ-1:0]              o_rvalid,
  output logic [7:0]                   o_rdata,
  output logic [CTRL_W-1:0]            o_sram_ctrl,
  input  logic [7:0]                   i_sram_dout,
  output logic                         o_busy
);

  localparam int unsigned IDX_W = $clog2(NREQ);
  // Control word is {din, row, col, write_en, sense_en}; hold is a bare sense.
  localparam logic [CTRL_W-1:0] HOLD_CTRL = CTRL_W'(1);
  localparam logic [7:0]        BURST_LIM = 8'(MAX_BURST);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_own, w_own_nxt;
  logic [7:0]       r_hold, w_hold_nxt, w_hold_inc;
  logic [NREQ-1:0]  r_rvalid, w_rvalid_nxt;
  logic [NREQ-1:0]  w_own_oh, w_others;
  logic [IDX_W-1:0] w_last;
  logic             w_contend, w_release, w_new_grant, w_issue, w_read;

  // Scan starts just after 'last' and wraps, so the first set bit found wins.
  function automatic logic [IDX_W-1:0] f_pick(input logic [NREQ-1:0] mask,
                                               input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] win   = '0;
    logic             found = 1'b0;
    logic [IDX_W-1:0] idx;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = IDX_W'((32'(last) + k) % NREQ);
      if (!found && mask[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

`ifdef IMG_SRAM_ARB_RR_EN
  logic [IDX_W-1:0] r_ptr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= IDX_W'(NREQ - 1);
    end else if (w_new_grant) begin
      r_ptr <= w_own_nxt;
    end
  end

  assign w_last = r_ptr;
`else
  assign w_last = IDX_W'(NREQ - 1);
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_own    <= '0;
      r_hold   <= '0;
      r_rvalid <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_own    <= w_own_nxt;
      r_hold   <= w_hold_nxt;
      r_rvalid <= w_rvalid_nxt;
    end
  end

  assign w_own_oh   = NREQ'(1) << r_own;
  assign w_others   = i_req & ~w_own_oh;
  assign w_contend  = |w_others;
  assign w_hold_inc = (r_hold == 8'hFF) ? r_hold : r_hold + 8'd1;
  assign w_release  = !i_req[r_own] ||
                      (w_contend && (!i_lock[r_own] || w_hold_inc >= BURST_LIM));

  always_comb begin
    w_state_nxt = r_state;
    w_own_nxt   = r_own;
    w_hold_nxt  = r_hold;
    w_new_grant = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (|i_req) begin
          w_state_nxt = StGrant;
          w_own_nxt   = f_pick(i_req, w_last);
          w_hold_nxt  = '0;
          w_new_grant = 1'b1;
        end
      end
      StGrant: begin
        if (w_release) begin
          w_hold_nxt = '0;
          // The owner is masked out so a yielding requester cannot win straight back.
          if (w_contend) begin
            w_own_nxt   = f_pick(w_others, w_last);
            w_new_grant = 1'b1;
          end else begin
            w_state_nxt = StIdle;
          end
        end else if (w_contend) begin
          w_hold_nxt = w_hold_inc;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_issue      = (r_state == StGrant) && i_req[r_own];
    o_sram_ctrl  = w_issue ? i_ctrl_in[r_own] : HOLD_CTRL;
    w_read       = w_issue && !i_ctrl_in[r_own][1] && i_ctrl_in[r_own][0];
    w_rvalid_nxt = w_read ? w_own_oh : '0;
    o_gnt        = (r_state == StGrant) ? w_own_oh : '0;
    o_busy       = (r_state == StGrant);
    o_rvalid     = r_rvalid;
  end

  assign o_rdata = i_sram_dout;

endmodule
